// File: rtl/add_pipe_pkg.sv
// Shared constants and types for the pipelined adder.
// Imported by the stage and top modules.
package add_pipe_pkg;

   localparam int ADD_WIDTH_DEFAULT = 32;
   localparam int ADD_CHUNK_DEFAULT = 8;

   typedef enum logic {
      MODE_ADD = 1'b0,
      MODE_SUB = 1'b1
   } mode_e;

   function automatic int add_stages(
      input int width,
      input int chunk
   );
      return width / chunk;
   endfunction

endpackage

// File: rtl/add_1bit.sv
// Single-bit full adder cell.
// Chained to build the per-stage chunk adder.
module add_1bit (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/add_pipe_stage.sv
// One chunk of the pipelined adder.
// Adds chunk IDX, registers result, operands and carry.
module add_pipe_stage
   import add_pipe_pkg::*;
#(
   parameter int WIDTH = ADD_WIDTH_DEFAULT,
   parameter int CHUNK = ADD_CHUNK_DEFAULT,
   parameter int IDX   = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_x,
   input  logic [WIDTH-1:0] in_y,
   input  logic [WIDTH-1:0] in_sum,
   input  logic             in_carry,
   input  logic             in_zero,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_x,
   output logic [WIDTH-1:0] out_y,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_carry,
   output logic             out_zero,
   output logic             out_ovf
);

   localparam int LO = CHUNK * IDX;

   logic [CHUNK-1:0] a;
   logic [CHUNK-1:0] b;
   logic [CHUNK-1:0] sum_c;
   logic [CHUNK:0]   c;
   logic [WIDTH-1:0] x_n;
   logic [WIDTH-1:0] y_n;
   logic [WIDTH-1:0] sum_n;
   logic             zero_n;

   assign a    = in_x[LO +: CHUNK];
   assign b    = in_y[LO +: CHUNK];
   assign c[0] = in_carry;

   for (genvar i = 0; i < CHUNK; i++) begin : g_bit
      add_1bit u_bit (
         .a  (a[i]),
         .b  (b[i]),
         .ci (c[i]),
         .s  (sum_c[i]),
         .co (c[i+1])
      );
   end

   assign in_ready = !out_valid || out_ready;

   // Clear consumed operand bits, merge chunk into result.
   always_comb begin
      x_n               = in_x;
      y_n               = in_y;
      sum_n             = in_sum;
      x_n[LO +: CHUNK]  = '0;
      y_n[LO +: CHUNK]  = '0;
      sum_n[LO +: CHUNK] = sum_c;
      zero_n            = in_zero & ~|sum_c;
   end

   // Stage register: advances only when successor is ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_x     <= '0;
         out_y     <= '0;
         out_sum   <= '0;
         out_carry <= 1'b0;
         out_zero  <= 1'b0;
         out_ovf   <= 1'b0;
      end else begin
         if (flush) begin
            out_valid <= 1'b0;
         end else if (in_ready) begin
            out_valid <= in_valid;
         end
         if (in_ready && in_valid) begin
            out_x     <= x_n;
            out_y     <= y_n;
            out_sum   <= sum_n;
            out_carry <= c[CHUNK];
            out_zero  <= zero_n;
            out_ovf   <= c[CHUNK-1] ^ c[CHUNK];
         end
      end
   end

endmodule

// File: rtl/add_pipe.sv
// Pipelined add/subtract with valid/ready flow control.
// Operand formation here; carry ripples across stages.
module add_pipe
   import add_pipe_pkg::*;
#(
   parameter int WIDTH = ADD_WIDTH_DEFAULT,
   parameter int CHUNK = ADD_CHUNK_DEFAULT
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             FLUSH,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   input  logic             C_IN,
   input  logic             SUB,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [WIDTH-1:0] Z,
   output logic             C_OUT,
   output logic             OVF,
   output logic             ZERO
);

   localparam int STAGES = add_stages(WIDTH, CHUNK);

   mode_e            mode;
   logic [WIDTH-1:0] y_eff;
   logic             c0;

   logic             valid_s [STAGES+1];
   logic             ready_s [STAGES+1];
   logic [WIDTH-1:0] x_s     [STAGES+1];
   logic [WIDTH-1:0] y_s     [STAGES+1];
   logic [WIDTH-1:0] sum_s   [STAGES+1];
   logic             carry_s [STAGES+1];
   logic             zero_s  [STAGES+1];
   logic             ovf_s   [STAGES];

   // Subtract is add of inverted Y with inverted borrow.
   always_comb begin
      mode  = mode_e'(SUB);
      y_eff = Y;
      c0    = C_IN;
      unique case (mode)
         MODE_ADD: begin
            y_eff = Y;
            c0    = C_IN;
         end
         MODE_SUB: begin
            y_eff = ~Y;
            c0    = ~C_IN;
         end
      endcase
   end

   assign valid_s[0]      = IN_VALID;
   assign ready_s[STAGES] = OUT_READY;
   assign x_s[0]          = X;
   assign y_s[0]          = y_eff;
   assign sum_s[0]        = '0;
   assign carry_s[0]      = c0;
   assign zero_s[0]       = 1'b1;

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      add_pipe_stage #(
         .WIDTH (WIDTH),
         .CHUNK (CHUNK),
         .IDX   (s)
      ) u_stage (
         .clk       (CLK),
         .rst_n     (RST_N),
         .flush     (FLUSH),
         .in_valid  (valid_s[s]),
         .in_ready  (ready_s[s]),
         .in_x      (x_s[s]),
         .in_y      (y_s[s]),
         .in_sum    (sum_s[s]),
         .in_carry  (carry_s[s]),
         .in_zero   (zero_s[s]),
         .out_valid (valid_s[s+1]),
         .out_ready (ready_s[s+1]),
         .out_x     (x_s[s+1]),
         .out_y     (y_s[s+1]),
         .out_sum   (sum_s[s+1]),
         .out_carry (carry_s[s+1]),
         .out_zero  (zero_s[s+1]),
         .out_ovf   (ovf_s[s])
      );
   end

   assign IN_READY  = ready_s[0];
   assign OUT_VALID = valid_s[STAGES];
   assign Z         = sum_s[STAGES];
   assign C_OUT     = carry_s[STAGES];
   assign ZERO      = zero_s[STAGES];
   assign OVF       = ovf_s[STAGES-1];

endmodule

// File: tb/tb_add_pipe.sv
// Scoreboard bench for add_pipe (WIDTH=32, CHUNK=8).
// Driver queues expected results; monitor pops on output.
module tb_add_pipe;

   typedef struct packed {
      logic [31:0] z;
      logic        c;
      logic        o;
      logic        zr;
   } exp_t;

   logic        CLK;
   logic        RST_N;
   logic        FLUSH;
   logic        IN_VALID;
   logic        IN_READY;
   logic [31:0] X;
   logic [31:0] Y;
   logic        C_IN;
   logic        SUB;
   logic        OUT_VALID;
   logic        OUT_READY;
   logic [31:0] Z;
   logic        C_OUT;
   logic        OVF;
   logic        ZERO;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_vec = 0;
   int   n_bad = 0;
   int   n_out = 0;
   int   run = 0;
   int   max_run = 0;

   add_pipe #(.WIDTH(32), .CHUNK(8)) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .FLUSH     (FLUSH),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .X         (X),
      .Y         (Y),
      .C_IN      (C_IN),
      .SUB       (SUB),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .Z         (Z),
      .C_OUT     (C_OUT),
      .OVF       (OVF),
      .ZERO      (ZERO)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic exp_t mk(
      input logic [31:0] z,
      input logic c,
      input logic o,
      input logic zr
   );
      exp_t e;
      e.z  = z;
      e.c  = c;
      e.o  = o;
      e.zr = zr;
      return e;
   endfunction

   task automatic chk(
      input string       nm,
      input logic [31:0] act,
      input logic [31:0] exp
   );
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h",
                  nm, act, exp);
      end
   endtask

   // Monitor: compare every output transfer in order.
   always @(negedge CLK) begin
      if (RST_N && OUT_VALID && OUT_READY) begin
         n_out++;
         run++;
         if (run > max_run) max_run = run;
         if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_out: got Z=%h want none",
                     Z);
         end else begin
            mon_e = exp_q.pop_front();
            chk("z", Z, mon_e.z);
            chk("c_out", 32'(C_OUT), 32'(mon_e.c));
            chk("ovf", 32'(OVF), 32'(mon_e.o));
            chk("zero", 32'(ZERO), 32'(mon_e.zr));
         end
      end else begin
         run = 0;
      end
   end

   task automatic push(
      input  logic [31:0] x,
      input  logic [31:0] y,
      input  logic        cin,
      input  logic        sub,
      input  exp_t        e,
      output int          waits
   );
      logic rdy;
      X = x;
      Y = y;
      C_IN = cin;
      SUB = sub;
      IN_VALID = 1'b1;
      waits = 0;
      rdy = 1'b0;
      forever begin
         @(negedge CLK);
         rdy = IN_READY;
         @(posedge CLK);
         if (rdy) break;
         waits++;
         if (waits > 50) begin
            n_vec++;
            n_bad++;
            $display("FAIL push_timeout: got 0 want 1");
            break;
         end
      end
      if (rdy) exp_q.push_back(e);
      #1;
   endtask

   task automatic idle(input int n);
      IN_VALID = 1'b0;
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic drain();
      IN_VALID = 1'b0;
      for (int k = 0; k < 60; k++) begin
         if (exp_q.size() == 0) break;
         @(negedge CLK);
      end
      chk("drain_left", exp_q.size(), 0);
      @(posedge CLK);
      #1;
   endtask

   int w;
   int tw;
   int lat;
   int acc;
   int n0;
   logic [31:0] i;
   logic rdy;

   initial begin
      RST_N = 1'b1;
      FLUSH = 1'b0;
      IN_VALID = 1'b0;
      X = '0;
      Y = '0;
      C_IN = 1'b0;
      SUB = 1'b0;
      OUT_READY = 1'b1;
      #1 RST_N = 1'b0;

      @(negedge CLK);
      chk("rst_out_valid", 32'(OUT_VALID), 0);
      chk("rst_z", Z, 0);
      chk("rst_c_out", 32'(C_OUT), 0);
      chk("rst_ovf", 32'(OVF), 0);
      chk("rst_zero", 32'(ZERO), 0);
      @(posedge CLK);
      #1 RST_N = 1'b1;
      #1 chk("rst_in_ready", 32'(IN_READY), 1);
      @(posedge CLK);
      #1;

      // wrap to zero, with latency measurement
      push(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0,
           mk(32'h0, 1'b1, 1'b0, 1'b1), w);
      IN_VALID = 1'b0;
      lat = 0;
      do begin
         @(negedge CLK);
         lat++;
      end while (!OUT_VALID && lat < 20);
      chk("latency", lat, 4);
      drain();

      // overflow and borrow corners, back-to-back
      push(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0,
           mk(32'h8000_0000, 1'b0, 1'b1, 1'b0), w);
      push(32'h8000_0000, 32'h1, 1'b0, 1'b1,
           mk(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0), w);
      push(32'd5, 32'd7, 1'b0, 1'b1,
           mk(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0), w);
      push(32'd5, 32'd7, 1'b1, 1'b1,
           mk(32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0), w);
      push(32'h1234_5678, 32'h0000_FFFF, 1'b1, 1'b0,
           mk(32'h1235_5678, 1'b0, 1'b0, 1'b0), w);
      push(32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 1'b1,
           mk(32'h0, 1'b1, 1'b0, 1'b1), w);
      drain();
      idle(2);

      // full-rate stream
      max_run = 0;
      tw = 0;
      for (int k = 1; k <= 20; k++) begin
         i = 32'(k);
         push(i, i << 8, 1'b0, 1'b0,
              mk(i * 257, 1'b0, 1'b0, 1'b0), w);
         tw += w;
      end
      drain();
      chk("stream_waits", tw, 0);
      chk("stream_run", max_run, 20);

      // stall with continuous offer
      OUT_READY = 1'b0;
      IN_VALID = 1'b1;
      C_IN = 1'b0;
      SUB = 1'b0;
      i = 32'd100;
      acc = 0;
      for (int c = 0; c < 10; c++) begin
         X = i;
         Y = i << 8;
         @(negedge CLK);
         rdy = IN_READY;
         if (c == 4 || c == 9) begin
            chk("stall_valid", 32'(OUT_VALID), 1);
            chk("stall_z", Z, 32'h6464);
         end
         @(posedge CLK);
         if (rdy) begin
            acc++;
            exp_q.push_back(mk(i * 257, 1'b0, 1'b0, 1'b0));
            i = i + 1;
         end
         #1;
      end
      chk("stall_accepted", acc, 4);
      chk("stall_in_ready", 32'(IN_READY), 0);
      OUT_READY = 1'b1;
      for (int k = 0; k < 6; k++) begin
         push(i, i << 8, 1'b0, 1'b0,
              mk(i * 257, 1'b0, 1'b0, 1'b0), w);
         i = i + 1;
      end
      drain();

      // reset with three ops in flight
      OUT_READY = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         i = 32'(k);
         push(i, i, 1'b0, 1'b0,
              mk(i * 2, 1'b0, 1'b0, 1'b0), w);
      end
      idle(1);
      chk("pre_rst_valid", 32'(OUT_VALID), 1);
      #1 RST_N = 1'b0;
      #1 chk("async_rst_valid", 32'(OUT_VALID), 0);
      chk("async_rst_z", Z, 0);
      exp_q.delete();
      #1 RST_N = 1'b1;
      OUT_READY = 1'b1;
      n0 = n_out;
      idle(8);
      chk("rst_no_stale", n_out - n0, 0);

      // flush with three ops in flight plus one offered
      OUT_READY = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         i = 32'(k);
         push(i, 32'd1, 1'b0, 1'b0,
              mk(i + 1, 1'b0, 1'b0, 1'b0), w);
      end
      idle(1);
      chk("pre_flush_valid", 32'(OUT_VALID), 1);
      X = 32'd9;
      Y = 32'd9;
      IN_VALID = 1'b1;
      FLUSH = 1'b1;
      @(negedge CLK);
      chk("flush_in_ready", 32'(IN_READY), 1);
      @(posedge CLK);
      #1;
      FLUSH = 1'b0;
      IN_VALID = 1'b0;
      chk("flush_valid", 32'(OUT_VALID), 0);
      exp_q.delete();
      OUT_READY = 1'b1;
      n0 = n_out;
      idle(8);
      chk("flush_no_stale", n_out - n0, 0);

      // normal operation resumes
      n0 = n_out;
      push(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0,
           mk(32'h0000_0100, 1'b0, 1'b0, 1'b0), w);
      drain();
      chk("resume_count", n_out - n0, 1);

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_bad);
      $finish;
   end

endmodule
